// File: rtl/mult_seq_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
package mult_seq_pkg;

  localparam int MULT_N = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } mult_state_e;

endpackage

// File: rtl/ripplecarryadder.sv
// N-bit ripple-carry adder; the single shared adder of the sequential multiplier.
module ripplecarryadder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign s[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[N];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add multiplier: one partial-product add per clock through a shared adder.
// Optional MULT_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are all zero.
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] c
);

  localparam int              CNT_W    = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  // start/done handshake: start is only sampled while IDLE (busy=0), including the
  // cycle in which done pulses; done is a one-cycle pulse and c holds until the next one.
  mult_state_e      state_q, state_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [2*N-1:0]   p_q, p_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2*N-1:0]   c_q, c_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [N-1:0]     addend;
  logic [N-1:0]     sum;
  logic             cout;
  logic [2*N-1:0]   p_shift;

  assign addend  = p_q[0] ? mcand_q : '0;
  assign p_shift = {cout, sum, p_q[N-1:1]};

  ripplecarryadder #(.N(N)) u_adder (
    .a    (p_q[2*N-1:N]),
    .b    (addend),
    .cin  (1'b0),
    .s    (sum),
    .cout (cout)
  );

`ifdef MULT_EARLY_EXIT_EN
  logic [N-1:0]     rem_mask;
  logic [CNT_W-1:0] rem_cnt;

  // After iteration count_q, the N-1-count_q unconsumed multiplier bits sit at the bottom of p_shift.
  assign rem_cnt  = LAST_CNT - count_q;
  assign rem_mask = {N{1'b1}} >> (count_q + CNT_W'(1));
`endif

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    p_d     = p_q;
    count_d = count_q;
    c_d     = c_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          p_d     = {{N{1'b0}}, b};
          count_d = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d     = p_shift;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) begin
          state_d = FINISH;
        end
`ifdef MULT_EARLY_EXIT_EN
        else if ((p_shift[N-1:0] & rem_mask) == '0) begin
          p_d     = p_shift >> rem_cnt;
          state_d = FINISH;
        end
`endif
      end
      FINISH: begin
        c_d     = p_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      p_q     <= '0;
      count_q <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
      count_q <= count_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign c    = c_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: directed scenarios plus random and exhaustive products against a*b.
module tb_mult_seq_ctrl;

  localparam int N = 4;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] c;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  mult_seq_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .c     (c)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int exp_latency(input logic [N-1:0] bv);
    int h = 0;
    for (int i = 0; i < N; i++) if (bv[i]) h = i;
`ifdef MULT_EARLY_EXIT_EN
    return h + 2;
`else
    return (h >= 0) ? N + 1 : 0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents operands with start for exactly one edge (the accepting edge); returns 1 after it.
  task automatic start_op(input logic [N-1:0] av, input logic [N-1:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    exp_q.push_back(W'(av) * W'(bv));
    step();
    start = 1'b0;
  endtask

  // Counts edges until done is seen; busy_cnt counts busy samples from the accepting edge on.
  task automatic wait_done(output int lat, output int busy_cnt, output bit to);
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      lat++;
      if (done) begin
        to = 1'b0;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
    checks++; if (c !== '0) begin errors++; $display("FAIL reset_c got %0d exp 0", c); end
    rst = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %0b exp 0", busy); end
  endtask

  task automatic test_basic();
    int lat, bc; bit to; logic [W-1:0] e;
    start_op(4'd15, 4'd15);
    wait_done(lat, bc, to);
    e = exp_q.pop_front();
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got none exp done"); end
    checks++; if (c !== e) begin errors++; $display("FAIL basic_c got %0d exp %0d", c, e); end
    checks++; if (lat != exp_latency(4'd15)) begin errors++; $display("FAIL basic_latency got %0d exp %0d", lat, exp_latency(4'd15)); end
    checks++; if (bc != exp_latency(4'd15)) begin errors++; $display("FAIL basic_busy_cycles got %0d exp %0d", bc, exp_latency(4'd15)); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %0b exp 0", done); end
    checks++; if (c !== e) begin errors++; $display("FAIL basic_c_hold got %0d exp %0d", c, e); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle got %0b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat, bc; bit to; logic [W-1:0] e;
    start_op(4'd7, 4'd9);
    wait_done(lat, bc, to);
    e = exp_q.pop_front();
    checks++; if (to || c !== e) begin errors++; $display("FAIL b2b_first_c got %0d exp %0d", c, e); end
    start_op(4'd3, 4'd5);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse got %0b exp 0", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy got %0b exp 1", busy); end
    checks++; if (c !== e) begin errors++; $display("FAIL b2b_c_hold got %0d exp %0d", c, e); end
    wait_done(lat, bc, to);
    e = exp_q.pop_front();
    checks++; if (to || c !== e) begin errors++; $display("FAIL b2b_second_c got %0d exp %0d", c, e); end
    checks++; if (lat != exp_latency(4'd5)) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", lat, exp_latency(4'd5)); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_second_pulse got %0b exp 0", done); end
  endtask

  task automatic test_start_during_run();
    int lat, bc; bit to; logic [W-1:0] e;
    start_op(4'd6, 4'd4);
    a = 4'd1; b = 4'd1; start = 1'b1;
    step();
    step();
    start = 1'b0;
    wait_done(lat, bc, to);
    e = exp_q.pop_front();
    checks++; if (to || c !== e) begin errors++; $display("FAIL run_start_c got %0d exp %0d", c, e); end
    checks++; if (lat + 2 != exp_latency(4'd4)) begin errors++; $display("FAIL run_start_latency got %0d exp %0d", lat + 2, exp_latency(4'd4)); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_start_queued got busy %0b exp 0", busy); end
    step();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL run_start_idle got busy %0b done %0b exp 0 0", busy, done); end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc; bit to; bit saw_done; logic [W-1:0] e;
    start_op(4'd5, 4'd7);
    step();
    step();
    #1 rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %0b exp 0", done); end
    checks++; if (c !== '0) begin errors++; $display("FAIL midrst_c got %0d exp 0", c); end
    step();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL midrst_no_done got activity exp none"); end
    start_op(4'd2, 4'd3);
    wait_done(lat, bc, to);
    e = exp_q.pop_front();
    checks++; if (to || c !== e) begin errors++; $display("FAIL midrst_next_c got %0d exp %0d", c, e); end
  endtask

  task automatic test_zero_operands();
    int lat, bc; bit to; logic [W-1:0] e;
    logic [N-1:0] av[2];
    logic [N-1:0] bv[2];
    av[0] = 4'd0;  bv[0] = 4'd13;
    av[1] = 4'd13; bv[1] = 4'd0;
    for (int k = 0; k < 2; k++) begin
      step();
      start_op(av[k], bv[k]);
      wait_done(lat, bc, to);
      e = exp_q.pop_front();
      checks++; if (to || c !== e) begin errors++; $display("FAIL zero_c[%0d] got %0d exp %0d", k, c, e); end
      checks++; if (lat != exp_latency(bv[k])) begin errors++; $display("FAIL zero_latency[%0d] got %0d exp %0d", k, lat, exp_latency(bv[k])); end
    end
  endtask

`ifdef MULT_EARLY_EXIT_EN
  task automatic test_early_exit();
    int lat, bc; bit to; logic [W-1:0] e;
    step();
    start_op(4'd9, 4'd1);
    wait_done(lat, bc, to);
    e = exp_q.pop_front();
    checks++; if (to || c !== e) begin errors++; $display("FAIL early_c got %0d exp %0d", c, e); end
    checks++; if (lat != 2) begin errors++; $display("FAIL early_latency got %0d exp 2", lat); end
    step();
    start_op(4'd9, 4'd8);
    wait_done(lat, bc, to);
    e = exp_q.pop_front();
    checks++; if (to || c !== e) begin errors++; $display("FAIL early_full_c got %0d exp %0d", c, e); end
    checks++; if (lat != N + 1) begin errors++; $display("FAIL early_full_latency got %0d exp %0d", lat, N + 1); end
  endtask
`endif

  task automatic test_random();
    int lat, bc; bit to; logic [W-1:0] e;
    logic [N-1:0] av, bv;
    for (int k = 0; k < 40; k++) begin
      av = N'($urandom_range(0, (1 << N) - 1));
      bv = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 1) == 0) begin
        for (int g = $urandom_range(1, 3); g > 0; g--) step();
      end
      start_op(av, bv);
      wait_done(lat, bc, to);
      e = exp_q.pop_front();
      checks++; if (to || c !== e) begin errors++; $display("FAIL rand_c a=%0d b=%0d got %0d exp %0d", av, bv, c, e); end
      checks++; if (lat != exp_latency(bv)) begin errors++; $display("FAIL rand_latency b=%0d got %0d exp %0d", bv, lat, exp_latency(bv)); end
    end
  endtask

  task automatic test_exhaustive();
    int lat, bc; bit to; logic [W-1:0] e;
    for (int i = 0; i < (1 << N); i++) begin
      for (int j = 0; j < (1 << N); j++) begin
        start_op(N'(i), N'(j));
        wait_done(lat, bc, to);
        e = exp_q.pop_front();
        checks++; if (to || c !== e) begin errors++; $display("FAIL sweep_c a=%0d b=%0d got %0d exp %0d", i, j, c, e); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_during_run();
    test_reset_mid_run();
    test_zero_operands();
`ifdef MULT_EARLY_EXIT_EN
    test_early_exit();
`endif
    test_random();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequential shift-and-add multiplier controller; replaces the unrolled combinational array multiplier where area matters.
- A single shared N-bit ripplecarryadder is time-multiplexed: one partial-product add per clock.
- Sits between a requesting engine (start/operands) and result consumers (done/c); start/done handshake with busy status.

Parameters:
- N, 4, operand width; product is 2N bits; N >= 2.
- CNT_W, $clog2(N+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  request; sampled only in IDLE
- a  input  N  multiplicand, captured on accepted start
- b  input  N  multiplier, captured on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; c valid and updated
- c  output  2N  unsigned product a*b, held until next done

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, c=0; internal regs (mcand, acc, P, count) cleared.
- States: IDLE, RUN, FINISH.
- IDLE: done deasserts (pulse). On edge with start=1: mcand<=a; P<={N'b0,b}; count<=0; busy<=1; -> RUN. Otherwise stay.
- RUN: each edge one iteration. sum = P[2N-1:N] + (P[0] ? mcand : 0) through the adder, cin=0, cout kept as bit N. P <= {cout, sum, P[N-1:1]} (logical right shift with carry-in at top); count<=count+1. When count reaches N-1, this edge is the last iteration -> FINISH.
- FINISH: c<=P; done<=1 for one cycle; busy<=0; -> IDLE. Result visible N+1 edges after the accepting edge.
- start while busy=1 (RUN/FINISH): ignored; operands not resampled; no queuing.
- Back-to-back: start asserted while done=1 (state IDLE) is accepted on that edge.
- Width rule: no overflow possible; 2N-bit result exact for unsigned inputs. a or b = 0 still takes full latency (no optional feature).
- Reset mid-operation: abort immediately, no done pulse, c cleared to 0.
- a/b changes after acceptance: no effect on the running operation.

Optional Feature:
- MULT_EARLY_EXIT_EN: when defined, RUN checks the unconsumed multiplier bits (P[N-1-count:0] after the shift). If all zero, it jumps to FINISH with P right-shifted by the remaining iteration count (barrel shift), so latency = (index of highest set bit of b)+2 edges. b=0 finishes after 1 RUN edge.
- Not defined: fixed latency of N+1 edges; no barrel shifter is synthesized.

Decomposition:
- Package mult_seq_pkg: state enum (IDLE, RUN, FINISH); default width constant MULT_N=4.
- Sub-module: existing ripplecarryadder (N-bit, a/b/cin/s/cout) instantiated once as the shared adder. Controller FSM, counter and shift register stay in mult_seq_ctrl.

Test Plan:
- Reset, then start with a=15, b=15 -> busy high for 5 cycles; done pulses once; c=8'hE1 (225) on the 5th edge after acceptance.
- a=7, b=9 then start on the done cycle with a=3, b=5 -> c=63, then c=15 with no idle gap; each done exactly one cycle.
- start pulsed again during RUN with a=1, b=1 -> ignored; first result (a=6, b=4) c=24 unaffected.
- rst asserted mid-RUN (after 2 iterations) -> busy, done, c immediately 0; no done; a subsequent operation 2*3 gives c=6.
- a=0, b=13 and a=13, b=0 -> c=0; feature off: 5-edge latency both cases.
- MULT_EARLY_EXIT_EN defined: a=9, b=1 -> c=9 with done after 2 edges; b=8 -> full latency; exhaustive 16x16 sweep matches a*b.
